// File: rtl/pe_ctrl_pkg.sv
// Shared types and default widths for the PE tile scheduler.
package pe_ctrl_pkg;

  localparam int PE_DATA_IN_W_DEF  = 1024;
  localparam int PE_DATA_OUT_W_DEF = 260;
  localparam int PE_LATENCY_DEF    = 2;
  localparam int OUT_FIFO_DEPTH_DEF = 4;
  localparam int CNT_W_DEF         = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } pe_state_e;

endpackage

// File: rtl/pe_result_fifo.sv
// Result FIFO: first-word-fall-through head, data+last payload, occupancy count.
// Push and pop may happen together, also when full.
module pe_result_fifo
  import pe_ctrl_pkg::*;
#(
  parameter int dataWidth = PE_DATA_OUT_W_DEF,
  parameter int depth     = OUT_FIFO_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [dataWidth-1:0]     push_data_i,
  input  logic                     push_last_i,
  input  logic                     pop_i,
  output logic [dataWidth-1:0]     head_data_o,
  output logic                     head_last_o,
  output logic [$clog2(depth):0]   count_o
);

  localparam int PW = $clog2(depth);

  logic [dataWidth:0] mem_q [depth];
  logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [PW:0]        count_q, count_d;
  logic               empty, full, do_push, do_pop;
  logic [dataWidth:0] head_word;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (PW+1)'(depth));
  assign do_pop  = pop_i && !empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push = push_i && (!full || do_pop);

  // Next occupancy from the push/pop pair.
  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) count_d = count_q + 1'b1;
    if (!do_push && do_pop) count_d = count_q - 1'b1;
  end

  // Payload storage; contents are only observed through the gated head.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= {push_last_i, push_data_i};
  end

  // Pointers wrap naturally because depth is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Head reads as zero while empty so the outputs are clean after reset.
  assign head_word   = empty ? '0 : mem_q[rd_ptr_q];
  assign head_data_o = head_word[dataWidth-1:0];
  assign head_last_o = head_word[dataWidth];
  assign count_o     = count_q;

  // Credits upstream must make a push into a full, non-popping FIFO impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push_i && full && !pop_i));

endmodule

// File: rtl/pe_tile_scheduler.sv
// PE tile scheduler: accepts a job of N vectors, streams them into a fixed-latency
// PE, and collects results in a credit-protected FIFO tagged with a last marker.
module pe_tile_scheduler
  import pe_ctrl_pkg::*;
#(
  parameter int peDataInWidth  = PE_DATA_IN_W_DEF,
  parameter int peDataOutWidth = PE_DATA_OUT_W_DEF,
  parameter int peLatency      = PE_LATENCY_DEF,
  parameter int outFifoDepth   = OUT_FIFO_DEPTH_DEF,
  parameter int cntWidth       = CNT_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      job_valid,
  output logic                      job_ready,
  input  logic [cntWidth-1:0]       job_len,
  input  logic                      vec_valid,
  output logic                      vec_ready,
  input  logic [peDataInWidth-1:0]  vec_data,
  output logic                      pe_valid,
  output logic [peDataInWidth-1:0]  pe_data_in,
  input  logic [peDataOutWidth-1:0] pe_data_out,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [peDataOutWidth-1:0] res_data,
  output logic                      res_last,
  output logic                      busy,
  output logic                      done
);

  localparam int FCW = $clog2(outFifoDepth) + 1;
  localparam int IFW = $clog2(peLatency + 1);

  pe_state_e                  state_q;
  logic [cntWidth-1:0]        len_q, issued_q, returned_q;
  logic [peLatency-1:0]       pipe_q, pipe_d;
  logic [peDataInWidth-1:0]   pe_data_q;
  logic                       done_q;
  logic                       vec_hs, tap, tag_last, res_pop;
  logic [FCW-1:0]             fifo_count;
  logic [IFW-1:0]             inflight;
  logic signed [31:0]         credits;

  // Count results still travelling through the PE.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < peLatency; i++) inflight = inflight + IFW'(pipe_q[i]);
  end

  // A FIFO slot is reserved for every vector already handed to the PE.
  assign credits   = 32'(outFifoDepth) - 32'(fifo_count) - 32'(inflight);
  assign vec_ready = (state_q == ST_RUN) && (issued_q < len_q) && (credits > 0);
  assign vec_hs    = vec_valid && vec_ready;

  assign pe_valid   = vec_hs;
  assign pe_data_in = vec_hs ? vec_data : pe_data_q;

  // Latency pipe: stage 0 takes the handshake bit, later stages shift.
  for (genvar gi = 0; gi < peLatency; gi++) begin : g_pipe
    if (gi == 0) begin : g_head
      assign pipe_d[gi] = vec_hs;
    end else begin : g_shift
      assign pipe_d[gi] = pipe_q[gi-1];
    end
  end

  assign tap      = pipe_q[peLatency-1];
  assign tag_last = (returned_q + cntWidth'(1)) == len_q;
  assign res_pop  = res_valid && res_ready;

  pe_result_fifo #(
    .dataWidth (peDataOutWidth),
    .depth     (outFifoDepth)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (tap),
    .push_data_i (pe_data_out),
    .push_last_i (tag_last),
    .pop_i       (res_pop),
    .head_data_o (res_data),
    .head_last_o (res_last),
    .count_o     (fifo_count)
  );

  assign res_valid = (fifo_count != '0);

  // Latency pipe and the held PE input vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_q    <= '0;
      pe_data_q <= '0;
    end else begin
      pipe_q <= pipe_d;
      if (vec_hs) pe_data_q <= vec_data;
    end
  end

  // Job sequencing FSM with job counters and the registered done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      issued_q   <= '0;
      returned_q <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (tap) returned_q <= returned_q + cntWidth'(1);
      case (state_q)
        ST_IDLE: begin
          if (job_valid) begin
            len_q      <= job_len;
            issued_q   <= '0;
            returned_q <= '0;
            if (job_len == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (vec_hs) begin
            issued_q <= issued_q + cntWidth'(1);
            if ((issued_q + cntWidth'(1)) == len_q) state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (res_pop && res_last) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign job_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_pe_tile_scheduler.sv
// Randomized scoreboard bench for pe_tile_scheduler with a behavioural PE model.
module tb_pe_tile_scheduler;

  localparam int DIW   = 1024;
  localparam int DOW   = 260;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;
  localparam int CW    = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           job_valid = 1'b0;
  logic           job_ready;
  logic [CW-1:0]  job_len = '0;
  logic           vec_valid = 1'b0;
  logic           vec_ready;
  logic [DIW-1:0] vec_data = '0;
  logic           pe_valid;
  logic [DIW-1:0] pe_data_in;
  logic [DOW-1:0] pe_data_out;
  logic           res_valid;
  logic           res_ready = 1'b0;
  logic [DOW-1:0] res_data;
  logic           res_last;
  logic           busy;
  logic           done;

  always #5 clk = ~clk;

  pe_tile_scheduler #(
    .peDataInWidth (DIW),
    .peDataOutWidth(DOW),
    .peLatency     (LAT),
    .outFifoDepth  (DEPTH),
    .cntWidth      (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .job_valid  (job_valid),
    .job_ready  (job_ready),
    .job_len    (job_len),
    .vec_valid  (vec_valid),
    .vec_ready  (vec_ready),
    .vec_data   (vec_data),
    .pe_valid   (pe_valid),
    .pe_data_in (pe_data_in),
    .pe_data_out(pe_data_out),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_last   (res_last),
    .busy       (busy),
    .done       (done)
  );

  typedef struct packed {
    logic [DOW-1:0] data;
    logic           last;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   done_cyc = -1;
  int   jobhs_cyc = -1;

  function automatic logic [DIW-1:0] rand_in();
    logic [DIW-1:0] r;
    for (int w = 0; w < DIW/32; w++) r[w*32 +: 32] = $urandom();
    return r;
  endfunction

  function automatic logic [DOW-1:0] rand_out();
    logic [DIW-1:0] r;
    r = rand_in();
    return r[DOW-1:0];
  endfunction

  // The PE's arithmetic: any fixed, data-dependent mapping will do.
  function automatic logic [DOW-1:0] pe_fn(input logic [DIW-1:0] v);
    logic [DOW-1:0] a, b;
    a = v[DOW-1:0];
    b = v[DIW-1 -: DOW];
    return (a ^ {b[DOW-2:0], b[DOW-1]}) + DOW'(v[511:480]);
  endfunction

  // Fixed-latency PE: non-load cycles carry junk so a wrong capture cycle shows.
  logic [DOW-1:0] pe_s0, pe_s1;
  always @(posedge clk) begin
    pe_s0 <= pe_valid ? pe_fn(pe_data_in) : rand_out();
    pe_s1 <= pe_s0;
  end
  assign pe_data_out = pe_s1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_out(input string name, input logic [DOW-1:0] act, input logic [DOW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_vec(input string name, input logic [DIW-1:0] act, input logic [DIW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got low64 %h expected low64 %h", name, act[63:0], exp[63:0]);
    end
  endtask

  // Monitor: protocol rules every cycle, scoreboard pop on each result handshake.
  logic           prev_hold = 1'b0;
  logic [DOW-1:0] prev_data = '0;
  logic           prev_last = 1'b0;
  exp_t           mon_e;
  always @(negedge clk) begin
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      chk_bit("job_ready_only_idle", job_ready, !busy);
      chk_bit("pe_valid_is_handshake", pe_valid, vec_valid && vec_ready);
      if (pe_valid) chk_vec("pe_data_in", pe_data_in, vec_data);
      if (prev_hold) begin
        chk_bit("res_valid_held", res_valid, 1'b1);
        chk_out("res_data_stable", res_data, prev_data);
        chk_bit("res_last_stable", res_last, prev_last);
      end
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got res_valid=1 expected no result (cycle %0d)", cyc);
        end else begin
          mon_e = exp_q.pop_front();
          $display("txn result data[31:0]=%h last=%0d cycle=%0d", res_data[31:0], res_last, cyc);
          chk_out("res_data", res_data, mon_e.data);
          chk_bit("res_last", res_last, mon_e.last);
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (job_valid && job_ready) jobhs_cyc = cyc;
      prev_hold = res_valid && !res_ready;
      prev_data = res_data;
      prev_last = res_last;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_values();
    chk_bit("rst_job_ready", job_ready, 1'b1);
    chk_bit("rst_vec_ready", vec_ready, 1'b0);
    chk_bit("rst_pe_valid", pe_valid, 1'b0);
    chk_vec("rst_pe_data_in", pe_data_in, '0);
    chk_bit("rst_res_valid", res_valid, 1'b0);
    chk_out("rst_res_data", res_data, '0);
    chk_bit("rst_res_last", res_last, 1'b0);
    chk_bit("rst_busy", busy, 1'b0);
    chk_bit("rst_done", done, 1'b0);
  endtask

  task automatic accept_job(input int len);
    int budget;
    job_valid = 1'b1;
    job_len   = CW'(len);
    budget    = 0;
    while (!job_ready && budget < 50) begin
      step();
      budget++;
    end
    chk_bit("job_accept", job_ready, 1'b1);
    step();
    job_valid = 1'b0;
  endtask

  // vmode 0: vec_valid always, 1: alternating, 2: random valid and random res_ready.
  task automatic run_job(input int len, input int vmode, input int stall);
    logic [DIW-1:0] vecs[$];
    logic [DIW-1:0] v;
    exp_t e;
    int idx, cycles, d0, first_hs;
    logic hs;
    $display("txn job len=%0d vmode=%0d stall=%0d", len, vmode, stall);
    for (int i = 0; i < len; i++) begin
      v = rand_in();
      vecs.push_back(v);
      e.data = pe_fn(v);
      e.last = (i == len - 1);
      exp_q.push_back(e);
    end
    d0 = done_cnt;
    accept_job(len);
    idx = 0;
    cycles = 0;
    first_hs = -1;
    while ((idx < len || done_cnt == d0) && cycles < 400) begin
      if (idx < len) begin
        vec_valid = (vmode == 0) ? 1'b1 : (vmode == 1) ? (cycles % 2 == 0) : 1'($urandom_range(0, 1));
        vec_data  = vecs[idx];
      end else begin
        vec_valid = 1'b0;
        vec_data  = rand_in();
      end
      res_ready = (cycles < stall) ? 1'b0 : (vmode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clk);
      hs = vec_valid && vec_ready;
      if (hs && first_hs < 0) first_hs = cyc;
      if (stall > 0 && cycles == stall - 1 && len > DEPTH && vmode == 0) begin
        chk_int("issued_while_stalled", idx, DEPTH);
        chk_bit("vec_ready_no_credit", vec_ready, 1'b0);
      end
      step();
      if (hs) idx++;
      cycles++;
    end
    vec_valid = 1'b0;
    res_ready = 1'b1;
    chk_bit("job_finished_in_budget", cycles < 400, 1'b1);
    chk_int("vectors_issued", idx, len);
    if (len > 0 && vmode == 0) chk_int("first_issue_latency", first_hs - jobhs_cyc, 1);
    if (len == 0) chk_bit("len0_done_latency", (done_cyc - jobhs_cyc) inside {[1:2]}, 1'b1);
    repeat (3) step();
    chk_int("done_pulses", done_cnt - d0, 1);
    chk_int("results_outstanding", exp_q.size(), 0);
  endtask

  // Two jobs with job_valid held high: the second must land the cycle after done.
  task automatic back_to_back();
    logic [DIW-1:0] vecs[$];
    logic [DIW-1:0] v;
    exp_t e;
    int idx, cycles, nhs, first_done, second_hs;
    logic hs;
    $display("txn back-to-back jobs len=2,2");
    for (int i = 0; i < 4; i++) begin
      v = rand_in();
      vecs.push_back(v);
      e.data = pe_fn(v);
      e.last = (i == 1) || (i == 3);
      exp_q.push_back(e);
    end
    job_len = CW'(2);
    job_valid = 1'b1;
    res_ready = 1'b1;
    idx = 0; cycles = 0; nhs = 0; first_done = -1; second_hs = -1;
    while ((idx < 4 || exp_q.size() != 0 || nhs < 2) && cycles < 100) begin
      vec_valid = (idx < 4);
      vec_data  = (idx < 4) ? vecs[idx] : '0;
      @(negedge clk);
      hs = vec_valid && vec_ready;
      if (done && first_done < 0) first_done = cyc;
      if (job_valid && job_ready) begin
        nhs++;
        if (nhs == 2) second_hs = cyc;
      end
      step();
      if (hs) idx++;
      if (nhs >= 2) job_valid = 1'b0;
      cycles++;
    end
    vec_valid = 1'b0;
    repeat (4) step();
    chk_bit("b2b_in_budget", cycles < 100, 1'b1);
    chk_int("b2b_accept_after_done", second_hs - first_done, 1);
  endtask

  // Reset with one result queued and two in the PE: everything is discarded.
  task automatic reset_midjob();
    int idx, cycles, d0, seen;
    logic hs;
    $display("txn mid-job reset len=3");
    d0 = done_cnt;
    accept_job(3);
    res_ready = 1'b0;
    idx = 0;
    cycles = 0;
    while (idx < 3 && cycles < 20) begin
      vec_valid = 1'b1;
      vec_data  = rand_in();
      @(negedge clk);
      hs = vec_valid && vec_ready;
      step();
      if (hs) idx++;
      cycles++;
    end
    vec_valid = 1'b0;
    chk_int("pre_reset_issued", idx, 3);
    chk_bit("pre_reset_res_valid", res_valid, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset_values();
    res_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (res_valid) seen++;
      step();
    end
    chk_int("no_results_after_reset", seen, 0);
    chk_int("no_done_after_reset", done_cnt - d0, 0);
  endtask

  initial begin
    int len, vm, st;
    repeat (3) step();
    rst = 1'b0;
    chk_reset_values();
    run_job(3, 0, 0);
    run_job(8, 0, 12);
    run_job(0, 0, 0);
    run_job(5, 1, 0);
    for (int j = 0; j < 8; j++) begin
      len = $urandom_range(0, 10);
      vm  = $urandom_range(0, 2);
      st  = (len > DEPTH && $urandom_range(0, 1) == 1) ? 10 : 0;
      run_job(len, vm, st);
    end
    back_to_back();
    reset_midjob();
    run_job(4, 2, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
